// File: rtl/af6cesrtl_prbsgen.sv
// ---------------------------------------------------------------------------
// af6cesrtl_prbsgen
//   Multi-channel test-pattern generator. One state entry per channel. Each
//   entry holds a PRBS15 (x^15+x^14+1) register or a sequential-byte counter.
//   Each request (channel + byte count) returns one 32-bit word that carries
//   the next 1..4 pattern bytes. Unused trailing bytes are driven to zero.
//   The CPU port configures a channel (enable, seq mode, reseed, single-shot
//   error insert) and reads its state back.
//
//   Pipeline: S1 registers the request and the channel state. S2 computes
//   the word, registers the outputs and writes the state back. A request in
//   cycle n gives ovld in cycle n+2, at one request per cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ireq/ilid/inob      request strobe, channel, valid bytes minus 1
//   ovld/odat/onob/olid result word (byte0 = odat[31:24]) with echoed tags
//   upen/upa/upws/uprs  CPU select, channel address, write / read strobes
//   updi/updo           CPU write data {reseed, set errp, en, seq} / read data
//   uprdy               one-cycle pulse when a CPU access completes
// ---------------------------------------------------------------------------
module af6cesrtl_prbsgen #(
  parameter int LID  = 7,
  parameter int LNUM = 1 << LID
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ireq,
  input  logic [LID-1:0] ilid,
  input  logic [1:0]     inob,
  output logic           ovld,
  output logic [31:0]    odat,
  output logic [1:0]     onob,
  output logic [LID-1:0] olid,
  input  logic           upen,
  input  logic [LID-1:0] upa,
  input  logic           upws,
  input  logic           uprs,
  input  logic [31:0]    updi,
  output logic [31:0]    updo,
  output logic           uprdy
);

  // Field order matches the CPU read-back layout {st, errp, en, seq}.
  typedef struct packed {
    logic [14:0] st;
    logic        errp;
    logic        en;
    logic        seq;
  } chan_t;

  chan_t          mem [LNUM];

  // Stage S1
  logic           s1_vld;
  logic [LID-1:0] s1_lid;
  logic [1:0]     s1_nob;
  chan_t          s1_ch;

  // S2 combinational results
  chan_t          s2_ch;
  logic [31:0]    s2_dat;

  // CPU access
  logic           cpu_pend;
  logic           cpu_wr;
  logic [LID-1:0] cpu_lid;
  logic [3:0]     cpu_wd;
  logic           cpu_d1;
  logic           cpu_go;
  logic           cpu_wr_go;
  logic           cpu_accept;
  chan_t          cpu_cur;
  chan_t          cpu_new;

  logic           unused_updi;
  assign unused_updi = ^updi[31:4];

  // -------------------------------------------------------------------------
  // Word generation
  // -------------------------------------------------------------------------
  logic [14:0] prbs_cur;
  logic [14:0] prbs_end;
  logic [31:0] prbs_word;
  logic        prbs_fb;
  logic [7:0]  seq_last;
  logic [31:0] seq_word;
  logic [31:0] word;

  always_comb begin
    // NOTE: blocking assignments here on purpose. prbs_cur is walked bit by
    // bit inside the loop. Each iteration must see the value the previous
    // iteration produced. Every variable gets a default first, so no latch
    // is inferred.
    prbs_cur  = (s1_ch.st == 15'd0) ? 15'h7FFF : s1_ch.st;  // escape lock-up
    prbs_end  = prbs_cur;
    prbs_word = '0;
    prbs_fb   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      prbs_fb          = prbs_cur[14] ^ prbs_cur[13];
      prbs_cur         = {prbs_cur[13:0], prbs_fb};
      prbs_word[31-i]  = prbs_fb;
      // Capture the register after exactly (inob+1)*8 steps.
      if (i[4:0] == {s1_nob, 3'b111}) prbs_end = prbs_cur;
    end

    seq_last = s1_ch.st[7:0];
    seq_word = '0;
    for (int k = 0; k < 4; k++) begin
      seq_word[31-8*k -: 8] = seq_last + 8'(k + 1);
    end

    word = s1_ch.seq ? seq_word : prbs_word;
    for (int k = 0; k < 4; k++) begin
      if (k > int'(s1_nob)) word[31-8*k -: 8] = 8'h00;
    end

    s2_ch  = s1_ch;
    s2_dat = '0;
    if (s1_ch.en) begin
      s2_dat      = word;
      // Error insert corrupts only the emitted copy. The stored state keeps
      // the clean sequence.
      s2_dat[24]  = word[24] ^ s1_ch.errp;
      s2_ch.errp  = 1'b0;
      s2_ch.st    = s1_ch.seq ? {s1_ch.st[14:8], seq_last + {6'd0, s1_nob} + 8'd1}
                              : prbs_end;
    end
  end

  // -------------------------------------------------------------------------
  // CPU access control
  // -------------------------------------------------------------------------
  // Only one access is in flight at a time. Strobes that arrive while an
  // access is pending or completing are dropped.
  assign cpu_accept = upen && (upws || uprs) && !cpu_pend && !cpu_d1 && !uprdy;
  // When S1 is empty there is no engine write-back this cycle. The CPU
  // access therefore cannot collide with S2 on any channel.
  assign cpu_go     = cpu_pend && !s1_vld;
  assign cpu_wr_go  = cpu_go && cpu_wr;

  always_comb begin
    cpu_cur      = mem[cpu_lid];
    cpu_new      = cpu_cur;
    cpu_new.seq  = cpu_wd[0];
    cpu_new.en   = cpu_wd[1];
    cpu_new.errp = cpu_cur.errp | cpu_wd[2];
    if (cpu_wd[3]) cpu_new.st = cpu_wd[0] ? 15'd0 : 15'h7FFF;
  end

  // -------------------------------------------------------------------------
  // Pipeline, state table and CPU registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_lid   <= '0;
      s1_nob   <= '0;
      s1_ch    <= '0;
      ovld     <= 1'b0;
      odat     <= '0;
      onob     <= '0;
      olid     <= '0;
      cpu_pend <= 1'b0;
      cpu_wr   <= 1'b0;
      cpu_lid  <= '0;
      cpu_wd   <= '0;
      cpu_d1   <= 1'b0;
      uprdy    <= 1'b0;
      updo     <= '0;
      // NOTE: the state table is cleared on reset. A RAM would not allow
      // this, so the table is a register array. A freshly reset channel is
      // then disabled, with zero state.
      for (int i = 0; i < LNUM; i++) mem[i] <= '0;
    end else begin
      s1_vld <= ireq;
      s1_lid <= ilid;
      s1_nob <= inob;
      // Same-channel forwarding keeps back-to-back requests contiguous.
      if (s1_vld && (s1_lid == ilid))
        s1_ch <= s2_ch;
      else if (cpu_wr_go && (cpu_lid == ilid))
        s1_ch <= cpu_new;
      else
        s1_ch <= mem[ilid];

      ovld <= s1_vld;
      odat <= s1_vld ? s2_dat : 32'd0;
      onob <= s1_vld ? s1_nob : 2'd0;
      olid <= s1_vld ? s1_lid : '0;

      if (s1_vld)    mem[s1_lid]  <= s2_ch;
      if (cpu_wr_go) mem[cpu_lid] <= cpu_new;

      if (cpu_accept) begin
        cpu_pend <= 1'b1;
        cpu_wr   <= upws;
        cpu_lid  <= upa;
        cpu_wd   <= updi[3:0];
      end else if (cpu_go) begin
        cpu_pend <= 1'b0;
      end
      if (cpu_go && !cpu_wr) updo <= {14'd0, cpu_cur};
      cpu_d1 <= cpu_go;
      uprdy  <= cpu_d1;
    end
  end

endmodule

// File: tb/tb_af6cesrtl_prbsgen.sv
module tb_af6cesrtl_prbsgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [6:0]  ilid;
  logic [1:0]  inob;
  logic        ovld;
  logic [31:0] odat;
  logic [1:0]  onob;
  logic [6:0]  olid;
  logic        upen;
  logic [6:0]  upa;
  logic        upws;
  logic        uprs;
  logic [31:0] updi;
  logic [31:0] updo;
  logic        uprdy;

  int checks = 0;
  int errors = 0;

  af6cesrtl_prbsgen #(.LID(7)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .ilid(ilid), .inob(inob),
    .ovld(ovld), .odat(odat), .onob(onob), .olid(olid),
    .upen(upen), .upa(upa), .upws(upws), .uprs(uprs),
    .updi(updi), .updo(updo), .uprdy(uprdy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one CPU access. lat is the number of ticks from the strobe until
  // uprdy is seen, or -1 if uprdy never comes.
  task automatic cpu_access(input logic wr, input logic [6:0] a,
                            input logic [31:0] d, output int lat);
    int n;
    upen = 1'b1; upws = wr; uprs = !wr; upa = a; updi = d;
    tick();
    upen = 1'b0; upws = 1'b0; uprs = 1'b0;
    n = 1;
    while (n <= 12 && !uprdy) begin
      tick();
      n++;
    end
    lat = uprdy ? n : -1;
    tick();
  endtask

  task automatic test_reset();
    int lat;
    checks++;
    if (ovld !== 1'b0 || odat !== 32'd0 || uprdy !== 1'b0 || updo !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ovld=%b odat=%h uprdy=%b updo=%h, required all 0",
               ovld, odat, uprdy, updo);
    end
    cpu_access(1'b0, 7'd5, 32'd0, lat);
    checks++;
    if (lat !== 3 || updo !== 32'd0) begin
      errors++;
      $display("FAIL reset_read_ch5: got lat=%0d updo=%h, required lat=3 updo=0", lat, updo);
    end
  endtask

  task automatic test_prbs();
    int lat;
    cpu_access(1'b1, 7'd5, 32'h0A, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL prbs_cfg_lat: got %0d, required 3", lat);
    end
    ireq = 1'b1; ilid = 7'd5; inob = 2'd1;
    tick();
    ireq = 1'b0;
    checks++;
    if (ovld !== 1'b0) begin
      errors++;
      $display("FAIL prbs_latency_early: got ovld=%b one cycle after request, required 0", ovld);
    end
    tick();
    checks++;
    if (ovld !== 1'b1 || olid !== 7'd5 || onob !== 2'd1 || odat !== 32'h0002_0000) begin
      errors++;
      $display("FAIL prbs_first: got ovld=%b olid=%0d onob=%0d odat=%h, required 1 5 1 00020000",
               ovld, olid, onob, odat);
    end
    tick();
    checks++;
    if (ovld !== 1'b0) begin
      errors++;
      $display("FAIL prbs_ovld_drop: got ovld=%b, required 0", ovld);
    end
    ireq = 1'b1; ilid = 7'd5; inob = 2'd3;
    tick();
    ireq = 1'b0;
    tick();
    checks++;
    if (ovld !== 1'b1 || onob !== 2'd3 || odat !== 32'h000C_0028) begin
      errors++;
      $display("FAIL prbs_second: got ovld=%b onob=%0d odat=%h, required 1 3 000c0028",
               ovld, onob, odat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    cpu_access(1'b1, 7'd3, 32'h0B, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL b2b_cfg_lat: got %0d, required 3", lat);
    end
    ireq = 1'b1; ilid = 7'd3; inob = 2'd3;
    tick();
    tick();
    ireq = 1'b0;
    checks++;
    if (ovld !== 1'b1 || olid !== 7'd3 || odat !== 32'h0102_0304) begin
      errors++;
      $display("FAIL b2b_first: got ovld=%b olid=%0d odat=%h, required 1 3 01020304", ovld, olid, odat);
    end
    tick();
    checks++;
    if (ovld !== 1'b1 || odat !== 32'h0506_0708) begin
      errors++;
      $display("FAIL b2b_second: got ovld=%b odat=%h, required 1 05060708", ovld, odat);
    end
    tick();
  endtask

  task automatic test_error_insert();
    int lat;
    cpu_access(1'b1, 7'd3, 32'h07, lat);
    ireq = 1'b1; ilid = 7'd3; inob = 2'd0;
    tick();
    tick();
    ireq = 1'b0;
    checks++;
    if (ovld !== 1'b1 || onob !== 2'd0 || odat !== 32'h0800_0000) begin
      errors++;
      $display("FAIL err_insert_word: got ovld=%b onob=%0d odat=%h, required 1 0 08000000",
               ovld, onob, odat);
    end
    tick();
    checks++;
    if (ovld !== 1'b1 || odat !== 32'h0A00_0000) begin
      errors++;
      $display("FAIL err_cleared_word: got ovld=%b odat=%h, required 1 0a000000", ovld, odat);
    end
    tick();
    cpu_access(1'b0, 7'd3, 32'd0, lat);
    checks++;
    if (lat !== 3 || updo !== 32'h0000_0053) begin
      errors++;
      $display("FAIL err_readback: got lat=%0d updo=%h, required 3 00000053", lat, updo);
    end
  endtask

  task automatic test_seq_wrap();
    int lat;
    logic [7:0]  base;
    logic [31:0] exp;
    // 61 back-to-back 4-byte requests advance ch3 from 0x0A to 0xFE.
    for (int i = 0; i <= 61; i++) begin
      if (i < 61) begin
        ireq = 1'b1; ilid = 7'd3; inob = 2'd3;
      end else begin
        ireq = 1'b0;
      end
      tick();
      if (i >= 1) begin
        base = 8'h0A + 8'(4 * (i - 1));
        exp  = {base + 8'd1, base + 8'd2, base + 8'd3, base + 8'd4};
        checks++;
        if (ovld !== 1'b1 || odat !== exp) begin
          errors++;
          $display("FAIL seq_stream[%0d]: got ovld=%b odat=%h, required 1 %h", i - 1, ovld, odat, exp);
        end
      end
    end
    tick();
    ireq = 1'b1; ilid = 7'd3; inob = 2'd3;
    tick();
    ireq = 1'b0;
    tick();
    checks++;
    if (ovld !== 1'b1 || odat !== 32'hFF00_0102) begin
      errors++;
      $display("FAIL seq_wrap_word: got ovld=%b odat=%h, required 1 ff000102", ovld, odat);
    end
    tick();
    cpu_access(1'b0, 7'd3, 32'd0, lat);
    checks++;
    if (lat !== 3 || updo !== 32'h0000_0013) begin
      errors++;
      $display("FAIL seq_wrap_readback: got lat=%0d updo=%h, required 3 00000013", lat, updo);
    end
  endtask

  task automatic test_disabled();
    int lat;
    cpu_access(1'b1, 7'd7, 32'h08, lat);
    ireq = 1'b1; ilid = 7'd7; inob = 2'd3;
    tick();
    ireq = 1'b0;
    tick();
    checks++;
    if (ovld !== 1'b1 || olid !== 7'd7 || onob !== 2'd3 || odat !== 32'd0) begin
      errors++;
      $display("FAIL disabled_word: got ovld=%b olid=%0d onob=%0d odat=%h, required 1 7 3 00000000",
               ovld, olid, onob, odat);
    end
    tick();
    cpu_access(1'b0, 7'd7, 32'd0, lat);
    checks++;
    if (lat !== 3 || updo !== 32'h0003_FFF8) begin
      errors++;
      $display("FAIL disabled_readback: got lat=%0d updo=%h, required 3 0003fff8", lat, updo);
    end
  endtask

  task automatic test_cpu_stall();
    int n;
    ireq = 1'b1; ilid = 7'd7; inob = 2'd0;
    upen = 1'b1; uprs = 1'b1; upws = 1'b0; upa = 7'd5;
    tick();
    upen = 1'b0; uprs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (uprdy !== 1'b0 || ovld !== 1'b1 || odat !== 32'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got uprdy=%b ovld=%b odat=%h, required 0 1 00000000",
                 i, uprdy, ovld, odat);
      end
    end
    ireq = 1'b0;
    n = 0;
    while (n < 10 && !uprdy) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 3 || uprdy !== 1'b1 || updo !== 32'h0000_0142) begin
      errors++;
      $display("FAIL stall_release: got ticks=%0d uprdy=%b updo=%h, required 3 1 00000142",
               n, uprdy, updo);
    end
    tick();
    checks++;
    if (uprdy !== 1'b0) begin
      errors++;
      $display("FAIL stall_pulse_width: got uprdy=%b, required 0", uprdy);
    end
  endtask

  task automatic test_rst_mid();
    int lat;
    int seen;
    ireq = 1'b1; ilid = 7'd5; inob = 2'd3;
    tick();
    upen = 1'b1; uprs = 1'b1; upa = 7'd3;
    tick();
    upen = 1'b0; uprs = 1'b0;
    checks++;
    if (ovld !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_traffic: got ovld=%b, required 1", ovld);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (ovld !== 1'b0 || odat !== 32'd0) begin
      errors++;
      $display("FAIL rst_flush: got ovld=%b odat=%h, required 0 00000000", ovld, odat);
    end
    rst = 1'b0; ireq = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (uprdy === 1'b1 || ovld === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_drop_pending: got %0d cycles with uprdy/ovld, required 0", seen);
    end
    cpu_access(1'b0, 7'd5, 32'd0, lat);
    checks++;
    if (lat !== 3 || updo !== 32'd0) begin
      errors++;
      $display("FAIL rst_state_ch5: got lat=%0d updo=%h, required 3 00000000", lat, updo);
    end
    cpu_access(1'b0, 7'd3, 32'd0, lat);
    checks++;
    if (lat !== 3 || updo !== 32'd0) begin
      errors++;
      $display("FAIL rst_state_ch3: got lat=%0d updo=%h, required 3 00000000", lat, updo);
    end
  endtask

  initial begin
    rst = 1'b1; ireq = 1'b0; ilid = '0; inob = '0;
    upen = 1'b0; upa = '0; upws = 1'b0; uprs = 1'b0; updi = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_prbs();
    test_back_to_back();
    test_error_insert();
    test_seq_wrap();
    test_disabled();
    test_cpu_stall();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
